// File: rtl/pixel_stream_sequencer.sv
// rtl/pixel_stream_sequencer.sv - frame-buffer to kernel-array pixel sequencer with write-back and corner counting
module pixel_stream_sequencer #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int PASSES     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [bitSize:0]      mem_addr,
    input  logic [pixelWidth-1:0] mem_rd_data,
    output logic                  mem_we,
    output logic [pixelWidth-1:0] mem_wr_data,
    output logic [bitSize:0]      pixel_position_or_address,
    output logic [pixelWidth-1:0] data_out,
    output logic                  we,
    input  logic [pixelWidth-1:0] result_in,
    input  logic                  harris_in,
    output logic                  busy,
    output logic [3:0]            pass_count,
    output logic [bitSize:0]      harris_count,
    output logic                  done
);

    localparam int AW = bitSize + 1;
    localparam logic [AW-1:0] LAST = AW'(N * N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_WRITE, S_GAP, S_READ, S_NEXT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  phase_q, phase_d;
    logic [AW-1:0]         slot_q, slot_d;
    logic [pixelWidth-1:0] pix_q, pix_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [3:0]            pass_q, pass_d;
    logic [AW-1:0]         hcount_q, hcount_d;

    logic                  slot_state;
    logic [AW-1:0]         prefetch_addr;

    // Slot-structured states toggle the phase bit; the rest run single-clock
    assign slot_state    = (state_q == S_PRIME) || (state_q == S_WRITE) ||
                           (state_q == S_GAP)   || (state_q == S_READ);
    assign prefetch_addr = (slot_q == LAST) ? LAST : slot_q + AW'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: phase, slot index, prefetched pixel and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 1'b0;
            slot_q   <= '0;
            pix_q    <= '0;
            acc_q    <= '0;
            pass_q   <= '0;
            hcount_q <= '0;
        end else begin
            phase_q  <= phase_d;
            slot_q   <= slot_d;
            pix_q    <= pix_d;
            acc_q    <= acc_d;
            pass_q   <= pass_d;
            hcount_q <= hcount_d;
        end
    end

    // Next-state logic: slot states advance only at the end of phase 1
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PRIME;
            S_PRIME: if (phase_q) state_d = S_WRITE;
            S_WRITE: if (phase_q && slot_q == LAST) state_d = S_GAP;
            S_GAP:   if (phase_q) state_d = S_READ;
            S_READ:  if (phase_q && slot_q == LAST) state_d = S_NEXT;
            S_NEXT:  state_d = (pass_q + 4'd1 == 4'(PASSES)) ? S_DONE : S_PRIME;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; the pixel for slot k+1 is addressed throughout slot k
    // and captured at the end of its phase 1 so data_out stays flat across a slot
    always_comb begin
        phase_d  = slot_state ? ~phase_q : 1'b0;
        slot_d   = '0;
        pix_d    = pix_q;
        acc_d    = acc_q;
        pass_d   = pass_q;
        hcount_d = hcount_q;
        if ((state_q == S_WRITE) || (state_q == S_READ)) begin
            slot_d = slot_q;
            if (phase_q) begin
                slot_d = (slot_q == LAST) ? '0 : slot_q + AW'(1);
            end
        end
        if (phase_q && ((state_q == S_PRIME) || (state_q == S_WRITE))) begin
            pix_d = mem_rd_data;
        end
        if (phase_q && (state_q == S_READ) && harris_in && (acc_q != LAST)) begin
            acc_d = acc_q + AW'(1);
        end
        if ((state_q == S_IDLE) && start) begin
            pass_d   = '0;
            hcount_d = '0;
        end
        if (state_q == S_NEXT) begin
            hcount_d = acc_q;
            acc_d    = '0;
            pass_d   = pass_q + 4'd1;
        end
    end

    // Output decode from state, slot and phase
    always_comb begin
        mem_addr                  = '0;
        mem_we                    = 1'b0;
        mem_wr_data               = '0;
        pixel_position_or_address = '0;
        data_out                  = '0;
        we                        = 1'b0;
        busy                      = (state_q != S_IDLE);
        done                      = (state_q == S_DONE);
        pass_count                = pass_q;
        harris_count              = hcount_q;
        case (state_q)
            S_WRITE: begin
                mem_addr                  = prefetch_addr;
                pixel_position_or_address = slot_q;
                we                        = 1'b1;
                data_out                  = pix_q;
            end
            S_READ: begin
                mem_addr                  = slot_q;
                pixel_position_or_address = slot_q;
                if (phase_q) begin
                    mem_we      = 1'b1;
                    mem_wr_data = result_in;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// tb/tb_pixel_stream_sequencer.sv - directed self-checking bench for pixel_stream_sequencer
module tb_pixel_stream_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_we;
    logic [7:0] mem_wr_data;
    logic [6:0] ppa;
    logic [7:0] data_out;
    logic       we;
    logic [7:0] result_in;
    logic       harris_in;
    logic       busy;
    logic [3:0] pass_count;
    logic [6:0] harris_count;
    logic       done;

    int         vectors = 0;
    int         miscompares = 0;
    int         hmode = 0;

    logic [7:0] mem [64];
    logic [7:0] exp_mem [64];
    logic       ld_en = 1'b0;
    logic [5:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    always #5 clk = ~clk;

    pixel_stream_sequencer #(.N(8), .bitSize(6), .pixelWidth(8), .PASSES(2)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .mem_addr                  (mem_addr),
        .mem_rd_data               (mem_rd_data),
        .mem_we                    (mem_we),
        .mem_wr_data               (mem_wr_data),
        .pixel_position_or_address (ppa),
        .data_out                  (data_out),
        .we                        (we),
        .result_in                 (result_in),
        .harris_in                 (harris_in),
        .busy                      (busy),
        .pass_count                (pass_count),
        .harris_count              (harris_count),
        .done                      (done)
    );

    // Frame buffer: one-clock read latency, write on mem_we, bench preload port
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr[5:0]];
        if (mem_we) mem[mem_addr[5:0]] <= mem_wr_data;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    assign harris_in = (hmode == 1) || ((hmode == 2) && ((ppa == 7'd10) || (ppa == 7'd20)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem(input int mode);
        for (int k = 0; k < 64; k++) begin
            ld_en   = 1'b1;
            ld_addr = 6'(k);
            ld_data = (mode == 0) ? 8'(k) : 8'(k * 3 + 1);
            exp_mem[k] = ld_data;
            step();
        end
        ld_en = 1'b0;
        step();
    endtask

    // One full two-pass run, checked clock by clock against the slot timeline
    task automatic run_check(input logic [7:0] res, input int hm, input int hold, input int exp_hc);
        int r, p, k;
        logic [7:0] prev_ppa, prev_data;
        hmode     = hm;
        result_in = res;
        start     = 1'b1;
        step();
        prev_ppa  = '0;
        prev_data = '0;
        for (int c = 0; c < 524; c++) begin
            start = (c < hold);
            if (c < 522) begin
                r = c % 261;
                p = c / 261;
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_run", 32'(done), 32'd0);
                if (r < 2) begin
                    chk("prime_we", 32'(we), 32'd0);
                    chk("prime_ppa", 32'(ppa), 32'd0);
                    chk("prime_addr", 32'(mem_addr), 32'd0);
                end else if (r < 130) begin
                    k = (r - 2) / 2;
                    chk("write_we", 32'(we), 32'd1);
                    chk("write_ppa", 32'(ppa), 32'(k));
                    chk("write_data", 32'(data_out), 32'((p == 0) ? exp_mem[k] : res));
                    chk("write_mem_we", 32'(mem_we), 32'd0);
                    if ((r - 2) % 2 == 1) begin
                        chk("write_prefetch", 32'(mem_addr), 32'((k < 63) ? k + 1 : 63));
                        chk("ph1_ppa_stable", 32'(ppa), 32'(prev_ppa));
                        chk("ph1_data_stable", 32'(data_out), 32'(prev_data));
                    end
                end else if (r < 132) begin
                    chk("gap_we", 32'(we), 32'd0);
                    chk("gap_ppa", 32'(ppa), 32'd0);
                    chk("gap_data", 32'(data_out), 32'd0);
                end else if (r < 260) begin
                    k = (r - 132) / 2;
                    chk("read_we", 32'(we), 32'd0);
                    chk("read_ppa", 32'(ppa), 32'(k));
                    chk("read_data", 32'(data_out), 32'd0);
                    chk("read_mem_we", 32'(mem_we), 32'((r - 132) % 2));
                    if ((r - 132) % 2 == 1) begin
                        chk("read_addr", 32'(mem_addr), 32'(k));
                        chk("read_wr_data", 32'(mem_wr_data), 32'(res));
                        chk("ph1_ppa_stable", 32'(ppa), 32'(prev_ppa));
                    end
                end else begin
                    chk("next_mem_we", 32'(mem_we), 32'd0);
                    chk("next_we", 32'(we), 32'd0);
                end
                if (c == 0) chk("pass_count_start", 32'(pass_count), 32'd0);
                if (c == 261) begin
                    chk("pass_count_p1", 32'(pass_count), 32'd1);
                    chk("harris_p1", 32'(harris_count), 32'(exp_hc));
                end
            end else if (c == 522) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_done", 32'(busy), 32'd1);
                chk("pass_count_done", 32'(pass_count), 32'd2);
            end else begin
                chk("busy_idle", 32'(busy), 32'd0);
                chk("done_idle", 32'(done), 32'd0);
                chk("pass_count_hold", 32'(pass_count), 32'd2);
                chk("harris_final", 32'(harris_count), 32'(exp_hc));
            end
            prev_ppa  = ppa;
            prev_data = data_out;
            step();
        end
        start = 1'b0;
        for (int k2 = 0; k2 < 64; k2++) exp_mem[k2] = res;
        for (int k2 = 0; k2 < 64; k2++) chk("mem_after_run", 32'(mem[k2]), 32'(res));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        result_in = 8'h00;
        step();
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_pass", 32'(pass_count), 32'd0);
        chk("rst_harris", 32'(harris_count), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_ppa", 32'(ppa), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        rst = 1'b0;
        load_mem(0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        run_check(8'hA5, 1, 0, 63);

        load_mem(1);
        run_check(8'h5A, 2, 50, 2);

        result_in = 8'h77;
        hmode     = 0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        for (int c = 0; c < 192; c++) step();
        chk("pre_abort_ppa", 32'(ppa), 32'd30);
        rst = 1'b1;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_ppa", 32'(ppa), 32'd0);
        step();
        chk("abort_mem_we2", 32'(mem_we), 32'd0);
        chk("abort_pass", 32'(pass_count), 32'd0);
        rst = 1'b0;
        step();
        step();
        chk("abort_idle", 32'(busy), 32'd0);
        for (int k = 0; k < 30; k++) exp_mem[k] = 8'h77;
        chk("partial_wb_29", 32'(mem[29]), 32'(exp_mem[29]));
        chk("partial_wb_30", 32'(mem[30]), 32'(exp_mem[30]));

        run_check(8'hC3, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
